// File: rtl/mul_div_unit.sv
// -----------------------------------------------------------------------------
// mul_div_unit
//   Iterative multiply/divide unit with architectural HI/LO registers. It sits
//   next to the ALU in the execute stage. MULT/MULTU use a shift-add multiplier
//   and DIV/DIVU use a restoring divider, one iteration per clock. A
//   multiply/divide keeps busy high for exactly WIDTH cycles. It then writes
//   hi/lo and pulses done for one cycle. MTHI/MTLO write hi/lo in a single
//   cycle.
//
// Parameters
//   WIDTH     operand / HI / LO width in bits (>= 2)
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     request, accepted only when !busy && !flush
//   op        0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
//   in1       multiplicand / dividend / MTHI-MTLO data
//   in2       multiplier / divisor
//   flush     abort the in-flight operation; it also wins over start
//   busy      iterative operation in progress
//   done      one-cycle pulse: hi/lo just updated by MULT*/DIV*
//   hi, lo    HI / LO registers
//   div_zero  one-cycle divide-by-zero pulse (only with MDU_DIVZERO_EN)
//
// Configuration macro: MDU_DIVZERO_EN
//   defined   : a divide by zero does not start. done and div_zero pulse in the
//               next cycle and hi/lo are left unchanged.
//   undefined : a divide by zero runs the full WIDTH cycles and pulses done.
//               hi/lo are not written.
// -----------------------------------------------------------------------------
module mul_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
`ifdef MDU_DIVZERO_EN
   ,
   output logic             div_zero
`endif
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   localparam logic [2:0] OP_MTHI = 3'd4;
   localparam logic [2:0] OP_MTLO = 3'd5;

   localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]   CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [WIDTH-1:0]   W_ZERO   = {WIDTH{1'b0}};
   localparam logic [WIDTH:0]     A_ZERO   = {(WIDTH+1){1'b0}};

   // Two's-complement negation of a WIDTH-bit value
   function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
      neg_w = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
   endfunction

   // Two's-complement negation of a 2*WIDTH-bit value
   function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
      neg_2w = ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
   endfunction

   // Magnitude of a signed WIDTH-bit value. The most negative value maps to
   // itself, and that is the correct unsigned magnitude.
   function automatic logic [WIDTH-1:0] abs_w(input logic [WIDTH-1:0] v);
      abs_w = v[WIDTH-1] ? neg_w(v) : v;
   endfunction

   // State
   logic [0:0]       state_r;
   logic [CNT_W-1:0] cnt_r;
   logic [WIDTH:0]   acc_r;      // mult: running upper product; div: partial remainder
   logic [WIDTH-1:0] qm_r;       // mult: multiplier / low product; div: dividend / quotient
   logic [WIDTH-1:0] opb_r;      // multiplicand or divisor magnitude
   logic             is_div_r;
   logic             neg_q_r;    // negate product / quotient at the end
   logic             neg_rem_r;  // negate remainder at the end (dividend was negative)
   logic             dz_r;       // divisor was zero: suppress the hi/lo write
   logic [WIDTH-1:0] hi_r;
   logic [WIDTH-1:0] lo_r;
   logic             done_r;
`ifdef MDU_DIVZERO_EN
   logic             div_zero_r;
`endif

   // Request decode
   logic             accept_s;
   logic             is_md_s;
   logic             is_div_op_s;
   logic             is_signed_s;
   logic             trap_s;
   logic             launch_s;
   logic [WIDTH-1:0] op_a_s;
   logic [WIDTH-1:0] op_b_s;

   assign accept_s    = start && (state_r == ST_IDLE) && !flush;
   assign is_md_s     = !op[2];
   assign is_div_op_s = !op[2] && op[1];
   assign is_signed_s = !op[2] && !op[0];
`ifdef MDU_DIVZERO_EN
   assign trap_s      = accept_s && is_div_op_s && (in2 == W_ZERO);
`else
   assign trap_s      = 1'b0;
`endif
   assign launch_s    = accept_s && is_md_s && !trap_s;
   assign op_a_s      = is_signed_s ? abs_w(in1) : in1;
   assign op_b_s      = is_signed_s ? abs_w(in2) : in2;

   // One iteration step
   logic [WIDTH:0]     mul_sum_s;
   logic [WIDTH:0]     div_shift_s;
   logic [WIDTH:0]     div_trial_s;
   logic [WIDTH:0]     iter_acc_s;
   logic [WIDTH-1:0]   iter_qm_s;
   logic [2*WIDTH-1:0] product_s;
   logic [WIDTH-1:0]   res_hi_s;
   logic [WIDTH-1:0]   res_lo_s;

   // Shift-add: add the multiplicand when the multiplier LSB is set, then
   // shift the {acc, qm} pair right by one bit.
   assign mul_sum_s   = acc_r + (qm_r[0] ? {1'b0, opb_r} : A_ZERO);
   // Restoring divide: shift the next dividend bit into the remainder and try
   // subtracting the divisor. A borrow (MSB set) means the remainder is kept.
   assign div_shift_s = {acc_r[WIDTH-1:0], qm_r[WIDTH-1]};
   assign div_trial_s = div_shift_s - {1'b0, opb_r};

   // Select the multiply or divide iteration result and apply the final sign fix-up
   always_comb begin
      iter_acc_s = acc_r;
      iter_qm_s  = qm_r;
      res_hi_s   = hi_r;
      res_lo_s   = lo_r;
      product_s  = {2*WIDTH{1'b0}};
      if (is_div_r) begin
         iter_acc_s = div_trial_s[WIDTH] ? div_shift_s : div_trial_s;
         iter_qm_s  = {qm_r[WIDTH-2:0], ~div_trial_s[WIDTH]};
         res_lo_s   = neg_q_r   ? neg_w(iter_qm_s) : iter_qm_s;
         res_hi_s   = neg_rem_r ? neg_w(iter_acc_s[WIDTH-1:0]) : iter_acc_s[WIDTH-1:0];
      end else begin
         iter_acc_s = {1'b0, mul_sum_s[WIDTH:1]};
         iter_qm_s  = {mul_sum_s[0], qm_r[WIDTH-1:1]};
         product_s  = {iter_acc_s[WIDTH-1:0], iter_qm_s};
         if (neg_q_r) begin
            product_s = neg_2w(product_s);
         end else begin
            product_s = product_s;
         end
         res_hi_s   = product_s[2*WIDTH-1:WIDTH];
         res_lo_s   = product_s[WIDTH-1:0];
      end
   end

   // FSM, iteration datapath, HI/LO registers and the done / div_zero pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         cnt_r      <= CNT_ZERO;
         acc_r      <= A_ZERO;
         qm_r       <= W_ZERO;
         opb_r      <= W_ZERO;
         is_div_r   <= 1'b0;
         neg_q_r    <= 1'b0;
         neg_rem_r  <= 1'b0;
         dz_r       <= 1'b0;
         hi_r       <= W_ZERO;
         lo_r       <= W_ZERO;
         done_r     <= 1'b0;
`ifdef MDU_DIVZERO_EN
         div_zero_r <= 1'b0;
`endif
      end else begin
         done_r     <= 1'b0;
`ifdef MDU_DIVZERO_EN
         div_zero_r <= 1'b0;
`endif
         if (state_r == ST_RUN) begin
            if (flush) begin
               state_r <= ST_IDLE;
               cnt_r   <= CNT_ZERO;
            end else begin
               acc_r <= iter_acc_s;
               qm_r  <= iter_qm_s;
               cnt_r <= cnt_r - CNT_ONE;
               if (cnt_r == CNT_ONE) begin
                  state_r <= ST_IDLE;
                  done_r  <= 1'b1;
                  if (!dz_r) begin
                     hi_r <= res_hi_s;
                     lo_r <= res_lo_s;
                  end else begin
                     hi_r <= hi_r;
                     lo_r <= lo_r;
                  end
               end else begin
                  state_r <= ST_RUN;
               end
            end
         end else begin
            if (launch_s) begin
               state_r   <= ST_RUN;
               cnt_r     <= CNT_LOAD;
               acc_r     <= A_ZERO;
               qm_r      <= op_a_s;
               opb_r     <= op_b_s;
               is_div_r  <= is_div_op_s;
               neg_q_r   <= is_signed_s && (in1[WIDTH-1] ^ in2[WIDTH-1]);
               neg_rem_r <= is_signed_s && is_div_op_s && in1[WIDTH-1];
               dz_r      <= is_div_op_s && (in2 == W_ZERO);
            end else if (trap_s) begin
               done_r     <= 1'b1;
`ifdef MDU_DIVZERO_EN
               div_zero_r <= 1'b1;
`endif
            end else if (accept_s) begin
               case (op)
                  OP_MTHI: hi_r <= in1;
                  OP_MTLO: lo_r <= in1;
                  default: begin
                     hi_r <= hi_r;
                     lo_r <= lo_r;
                  end
               endcase
            end else begin
               state_r <= ST_IDLE;
            end
         end
      end
   end

   assign busy = (state_r == ST_RUN);
   assign done = done_r;
   assign hi   = hi_r;
   assign lo   = lo_r;
`ifdef MDU_DIVZERO_EN
   assign div_zero = div_zero_r;
`endif

endmodule

// File: tb/tb_mul_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mul_div_unit
//   Directed self-checking bench for mul_div_unit with WIDTH=32. Every expected
//   value is a hand-computed constant.
// -----------------------------------------------------------------------------
module tb_mul_div_unit;

   localparam int W = 32;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [2:0]   op;
   logic [W-1:0] in1;
   logic [W-1:0] in2;
   logic         flush;
   logic         busy;
   logic         done;
   logic [W-1:0] hi;
   logic [W-1:0] lo;
`ifdef MDU_DIVZERO_EN
   logic         div_zero;
`endif

   int total = 0;
   int bad   = 0;

   mul_div_unit #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .op       (op),
      .in1      (in1),
      .in2      (in2),
      .flush    (flush),
      .busy     (busy),
      .done     (done),
      .hi       (hi),
      .lo       (lo)
`ifdef MDU_DIVZERO_EN
      ,
      .div_zero (div_zero)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Present a request for one cycle. The task returns #1 after the accept edge.
   task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      start = 1'b1;
      op    = o;
      in1   = a;
      in2   = b;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Count edges until done is seen, up to a bounded budget.
   task automatic wait_done(output int n);
      n = 0;
      while (done !== 1'b1 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   int n;
   int pulses;

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      op    = 3'd0;
      in1   = 32'h0;
      in2   = 32'h0;
      flush = 1'b0;
      #12;
      check("rst_busy", 64'(busy), 64'h0);
      check("rst_done", 64'(done), 64'h0);
      check("rst_hi",   64'(hi),   64'h0);
      check("rst_lo",   64'(lo),   64'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // MULT -1 * 3
      issue(3'd0, 32'hFFFF_FFFF, 32'd3);
      check("mult_busy_rise", 64'(busy), 64'h1);
      wait_done(n);
      check("mult_latency", 64'(n), 64'd32);
      check("mult_busy_fall", 64'(busy), 64'h0);
      check("mult_hi", 64'(hi), 64'hFFFF_FFFF);
      check("mult_lo", 64'(lo), 64'hFFFF_FFFD);
      @(posedge clk); #1;
      check("done_one_cycle", 64'(done), 64'h0);

      // MULTU 0xFFFFFFFF * 3
      issue(3'd1, 32'hFFFF_FFFF, 32'd3);
      wait_done(n);
      check("multu_hi", 64'(hi), 64'h2);
      check("multu_lo", 64'(lo), 64'hFFFF_FFFD);

      // MULT MIN * MIN = 2^62
      issue(3'd0, 32'h8000_0000, 32'h8000_0000);
      wait_done(n);
      check("mult_min_hi", 64'(hi), 64'h4000_0000);
      check("mult_min_lo", 64'(lo), 64'h0);

      // DIV -7 / 2
      issue(3'd2, 32'hFFFF_FFF9, 32'd2);
      wait_done(n);
      check("div_latency", 64'(n), 64'd32);
      check("div_lo", 64'(lo), 64'hFFFF_FFFD);
      check("div_hi", 64'(hi), 64'hFFFF_FFFF);

      // DIV 7 / -2
      issue(3'd2, 32'd7, 32'hFFFF_FFFE);
      wait_done(n);
      check("div_neg_lo", 64'(lo), 64'hFFFF_FFFD);
      check("div_neg_hi", 64'(hi), 64'h1);

      // DIVU 100 / 7; the operands change right after the accept edge
      issue(3'd3, 32'd100, 32'd7);
      in1 = 32'h0;
      in2 = 32'h0;
      wait_done(n);
      check("divu_lo", 64'(lo), 64'd14);
      check("divu_hi", 64'(hi), 64'd2);

      // DIV MIN / -1
      issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done(n);
      check("div_ovf_lo", 64'(lo), 64'h8000_0000);
      check("div_ovf_hi", 64'(hi), 64'h0);

      // MTHI, MTLO
      issue(3'd4, 32'h1234, 32'h0);
      check("mthi_busy", 64'(busy), 64'h0);
      check("mthi_done", 64'(done), 64'h0);
      check("mthi_hi",   64'(hi),   64'h1234);
      issue(3'd5, 32'h5678, 32'h0);
      check("mtlo_busy", 64'(busy), 64'h0);
      check("mtlo_done", 64'(done), 64'h0);
      check("mtlo_lo",   64'(lo),   64'h5678);
      check("mtlo_hi_keep", 64'(hi), 64'h1234);

      // op 6 is a no-op
      issue(3'd6, 32'hDEAD, 32'hBEEF);
      check("nop_busy", 64'(busy), 64'h0);
      check("nop_hi", 64'(hi), 64'h1234);
      check("nop_lo", 64'(lo), 64'h5678);

      // MULT 5*6, with an MTHI presented at N+5 that must be ignored
      issue(3'd0, 32'd5, 32'd6);
      repeat (4) @(posedge clk);
      @(negedge clk);
      start = 1'b1;
      op    = 3'd4;
      in1   = 32'hDEAD;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(n);
      check("ign_latency", 64'(n), 64'd27);
      check("ign_hi", 64'(hi), 64'h0);
      check("ign_lo", 64'(lo), 64'd30);

      // MULT 7*9 flushed at N+10
      issue(3'd0, 32'd7, 32'd9);
      repeat (9) @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush_busy", 64'(busy), 64'h0);
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done === 1'b1) pulses++;
      end
      check("flush_no_done", 64'(pulses), 64'h0);
      check("flush_hi", 64'(hi), 64'h0);
      check("flush_lo", 64'(lo), 64'd30);

      // A start in the same cycle as a flush is dropped
      @(negedge clk);
      start = 1'b1;
      flush = 1'b1;
      op    = 3'd4;
      in1   = 32'hCAFE;
      @(posedge clk); #1;
      start = 1'b0;
      flush = 1'b0;
      check("flush_beats_start", 64'(hi), 64'h0);

      // Back-to-back: DIVU accepted in the done cycle of MULT 0x10000*0x10000
      issue(3'd0, 32'h0001_0000, 32'h0001_0000);
      wait_done(n);
      check("b2b_mult_hi", 64'(hi), 64'h1);
      start = 1'b1;
      op    = 3'd3;
      in1   = 32'd100;
      in2   = 32'd7;
      @(posedge clk); #1;
      start = 1'b0;
      check("b2b_busy", 64'(busy), 64'h1);
      repeat (16) @(posedge clk);
      #1;
      check("b2b_hold_hi", 64'(hi), 64'h1);
      check("b2b_hold_lo", 64'(lo), 64'h0);
      wait_done(n);
      check("b2b_latency", 64'(n), 64'd16);
      check("b2b_div_lo", 64'(lo), 64'd14);
      check("b2b_div_hi", 64'(hi), 64'd2);

      // Asynchronous reset in the middle of a MULT
      issue(3'd0, 32'd3, 32'd3);
      repeat (6) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_busy", 64'(busy), 64'h0);
      check("arst_done", 64'(done), 64'h0);
      check("arst_hi",   64'(hi),   64'h0);
      check("arst_lo",   64'(lo),   64'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Divide by zero; hi/lo are preloaded with known values first
      issue(3'd4, 32'hAAAA, 32'h0);
      issue(3'd5, 32'hBBBB, 32'h0);
      issue(3'd2, 32'd5, 32'd0);
`ifdef MDU_DIVZERO_EN
      check("dz_busy", 64'(busy), 64'h0);
      check("dz_done", 64'(done), 64'h1);
      check("dz_flag", 64'(div_zero), 64'h1);
      @(posedge clk); #1;
      check("dz_done_clr", 64'(done), 64'h0);
      check("dz_flag_clr", 64'(div_zero), 64'h0);
`else
      check("dz_busy", 64'(busy), 64'h1);
      wait_done(n);
      check("dz_latency", 64'(n), 64'd32);
`endif
      check("dz_hi", 64'(hi), 64'hAAAA);
      check("dz_lo", 64'(lo), 64'hBBBB);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
